bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master front end that sits directly upstream of memory_top: instruction fetch (port I, read-only) and load/store unit (port D) share the single memory bus.
- Grants one master at a time and issues a one-cycle bus request.
- Holds the bus until memory_top pulses completion, then returns masked read data and a done pulse to the granted master.
- Screens illegal size codes so memory_top never receives a request it cannot finish.

Parameters:
- WATCHDOG_W, 16, width of outstanding-request cycle counter; saturation sets sticky o_timeout.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_if_req  in  1  port I request, level; held until o_if_done
- i_if_address  in  32  port I byte address; always a word read (bhw 3'b100, write 0)
- o_if_data  out  32  port I read data, valid with o_if_done
- o_if_done  out  1  port I one-cycle completion pulse
- i_ls_req  in  1  port D request, level; held until o_ls_done
- i_ls_address  in  32  port D byte address
- i_ls_data  in  32  port D write data, right-aligned
- i_ls_bhw  in  3  port D size: 3'b100 word, 3'b010 half, 3'b001 byte
- i_ls_write  in  1  port D 1 = write, 0 = read
- o_ls_data  out  32  port D read data, zero-extended, valid with o_ls_done
- o_ls_done  out  1  port D one-cycle completion pulse
- o_ls_err  out  1  pulses together with o_ls_done for an illegal bhw
- o_bus_address  out  32  to memory_top i_bus_address
- o_bus_data  out  32  to memory_top i_bus_data
- o_bhw  out  3  to memory_top i_bhw
- o_write_notread  out  1  to memory_top i_write_notread
- o_bus_DV  out  1  one-cycle request strobe to memory_top
- i_bus_data  in  32  from memory_top o_bus_data
- i_bus_DV  in  1  from memory_top o_bus_DV completion pulse
- o_timeout  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = D (so port I wins the first tie), watchdog 0.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - Neither request high: stay in IDLE.
  - One request high: grant it.
  - Both high: grant the port not in last_grant (round-robin).
  - On grant, latch address, data, bhw and write into registers and update last_grant.
  - Port D with bhw not in {001, 010, 100} → ERR; the request is never forwarded.
  - Any other grant → ISSUE.
- ISSUE: o_bus_DV = 1 for exactly this cycle, bus fields driven from the latched registers → WAIT. Bus fields stay stable from ISSUE through WAIT.
- WAIT:
  - o_bus_DV = 0; watchdog increments every cycle.
  - When the watchdog saturates (all ones), set o_timeout and remain in WAIT. memory_top cannot be aborted.
  - i_bus_DV = 1 → capture data → RESP.
- RESP: granted port's done = 1 for one cycle with registered data → IDLE. Watchdog cleared.
- ERR: o_ls_done = 1, o_ls_err = 1, o_ls_data = 0 for one cycle → IDLE.
- Read data masking (memory_top returns sub-word data in the low bytes and its upper bytes are not guaranteed):
  - byte → {24'h0, [7:0]}
  - half → {16'h0, [15:0]}
  - word → unmodified
- Writes: data is passed through unmodified; the captured read value is still returned on done, and masters ignore it.
- Latency:
  - Request sampled at edge N → o_bus_DV high in cycle N+1.
  - i_bus_DV sampled at edge M → done high in cycle M+1.
  - Illegal request: done one cycle after sampling.
- Handshake: a master drops req in the cycle after its done unless it issues a new request. IDLE samples req only in the cycle following RESP/ERR, so a held req is treated as a new transaction.
- i_bus_DV arriving outside WAIT (stray, e.g. after reset mid-transaction, since memory_top has no reset) is ignored; no done pulse is generated.
- Asserting i_rst in any state returns to IDLE immediately; any in-flight grant is discarded.
- Done outputs of the non-granted port remain 0.
- Request changes while not in IDLE are ignored.

Decomposition:
- Shared package (memory bus definitions): localparams BHW_WORD = 3'b100, BHW_HALF = 3'b010, BHW_BYTE = 3'b001, BHW_NONE = 3'b000; FSM state encodings.
- One natural sub-module, rr_arbiter2: two requests in, last_grant register, grant out.

Test Plan:
- Port I only, address 0x0000_0010, memory responds 3 cycles after o_bus_DV with 0xDEADBEEF → o_bus_DV at N+1 with bhw 100 and write 0; o_if_done with o_if_data 0xDEADBEEF at M+1; o_ls_done stays 0.
- Both requests at the same edge after reset → port I granted first, port D next; repeat both held → grants alternate I, D, I, D.
- Port D byte read at 0x0000_1003, memory returns 0xFFFF_FFA5 → o_ls_data = 0x0000_00A5. Half read returning 0x1234_BEEF → 0x0000_BEEF.
- Port D write, bhw 010, data 0x0000_CAFE, address 0x0000_2000 → bus fields o_bhw 010, o_write_notread 1, o_bus_data 0x0000_CAFE, held stable until i_bus_DV; then o_ls_done.
- Port D with bhw 3'b000 → no o_bus_DV; o_ls_done and o_ls_err both pulse one cycle after sampling, o_ls_data 0.
- Assert i_rst during WAIT, then inject a stray i_bus_DV while in IDLE → no done pulse; a following port I request completes normally. With WATCHDOG_W = 4 and no response, o_timeout is set after 15 WAIT cycles and stays set.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Memory bus definitions shared by the two-master arbiter front end.
// Size codes, FSM states and read-data masking live here.
package bus_arbiter_pkg;

  localparam logic [2:0] BHW_WORD = 3'b100;
  localparam logic [2:0] BHW_HALF = 3'b010;
  localparam logic [2:0] BHW_BYTE = 3'b001;
  localparam logic [2:0] BHW_NONE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } arb_state_t;

  function automatic logic bhw_legal(input logic [2:0] bhw);
    return (bhw == BHW_WORD) || (bhw == BHW_HALF) || (bhw == BHW_BYTE);
  endfunction

  // memory_top leaves the upper bytes of sub-word reads undefined
  function automatic logic [31:0] mask_read(input logic [31:0] data, input logic [2:0] bhw);
    logic [31:0] masked;
    case (bhw)
      BHW_BYTE: masked = {24'h0, data[7:0]};
      BHW_HALF: masked = {16'h0, data[15:0]};
      default:  masked = data;
    endcase
    return masked;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// Two-way round-robin arbiter; remembers which port was granted last.
// last_ls resets high so the instruction port wins the first tie.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_ls,
  input  logic advance,
  output logic grant_valid,
  output logic grant_ls
);

  logic last_ls;

  always_comb begin
    grant_valid = req_if | req_ls;
    grant_ls    = req_ls & (~req_if | ~last_ls);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ls <= 1'b1;
    end else if (advance && grant_valid) begin
      last_ls <= grant_ls;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Front end sharing memory_top between instruction fetch and load/store.
// One transaction at a time: grant, one-cycle strobe, wait, respond.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WATCHDOG_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_address,
  output logic [31:0] o_if_data,
  output logic        o_if_done,
  input  logic        i_ls_req,
  input  logic [31:0] i_ls_address,
  input  logic [31:0] i_ls_data,
  input  logic [2:0]  i_ls_bhw,
  input  logic        i_ls_write,
  output logic [31:0] o_ls_data,
  output logic        o_ls_done,
  output logic        o_ls_err,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_data,
  output logic [2:0]  o_bhw,
  output logic        o_write_notread,
  output logic        o_bus_DV,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV,
  output logic        o_timeout
);

  localparam logic [WATCHDOG_W-1:0] WD_MAX = '1;
  localparam logic [WATCHDOG_W-1:0] WD_ONE = {{(WATCHDOG_W-1){1'b0}}, 1'b1};

  arb_state_t state, next_state;

  logic [31:0]           addr_q, wdata_q, rdata_q;
  logic [2:0]            bhw_q, grant_bhw;
  logic                  write_q, owner_ls_q;
  logic [WATCHDOG_W-1:0] watchdog, watchdog_inc;
  logic                  timeout_q;
  logic                  grant_valid, grant_ls, in_idle;

  assign in_idle = (state == ST_IDLE);

  rr_arbiter2 u_rr (
    .clk         (i_clk),
    .rst         (i_rst),
    .req_if      (i_if_req),
    .req_ls      (i_ls_req),
    .advance     (in_idle),
    .grant_valid (grant_valid),
    .grant_ls    (grant_ls)
  );

  assign grant_bhw    = grant_ls ? i_ls_bhw : BHW_WORD;
  assign watchdog_inc = watchdog + WD_ONE;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    o_bus_DV   = 1'b0;
    o_if_done  = 1'b0;
    o_ls_done  = 1'b0;
    o_ls_err   = 1'b0;
    o_if_data  = 32'h0;
    o_ls_data  = 32'h0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          next_state = bhw_legal(grant_bhw) ? ST_ISSUE : ST_ERR;
        end
      end
      ST_ISSUE: begin
        o_bus_DV   = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_bus_DV) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_ls_q) begin
          o_ls_done = 1'b1;
          o_ls_data = rdata_q;
        end else begin
          o_if_done = 1'b1;
          o_if_data = rdata_q;
        end
        next_state = ST_IDLE;
      end
      ST_ERR: begin
        o_ls_done  = 1'b1;
        o_ls_err   = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request fields are captured once at grant so the bus stays stable while waiting
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      bhw_q      <= BHW_NONE;
      write_q    <= 1'b0;
      owner_ls_q <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      if (in_idle && grant_valid) begin
        addr_q     <= grant_ls ? i_ls_address : i_if_address;
        wdata_q    <= grant_ls ? i_ls_data : 32'h0;
        bhw_q      <= grant_bhw;
        write_q    <= grant_ls & i_ls_write;
        owner_ls_q <= grant_ls;
      end
      if (state == ST_WAIT && i_bus_DV) begin
        rdata_q <= mask_read(i_bus_data, bhw_q);
      end
    end
  end

  // memory_top cannot be aborted, so saturation only raises a sticky flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      watchdog  <= '0;
      timeout_q <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (watchdog != WD_MAX) begin
        watchdog <= watchdog_inc;
        if (watchdog_inc == WD_MAX) begin
          timeout_q <= 1'b1;
        end
      end
    end else begin
      watchdog <= '0;
    end
  end

  assign o_bus_address   = addr_q;
  assign o_bus_data      = wdata_q;
  assign o_bhw           = bhw_q;
  assign o_write_notread = write_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the two-master arbiter.
module tb_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_address;
  logic [31:0] o_if_data;
  logic        o_if_done;
  logic        i_ls_req;
  logic [31:0] i_ls_address;
  logic [31:0] i_ls_data;
  logic [2:0]  i_ls_bhw;
  logic        i_ls_write;
  logic [31:0] o_ls_data;
  logic        o_ls_done;
  logic        o_ls_err;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_data;
  logic [2:0]  o_bhw;
  logic        o_write_notread;
  logic        o_bus_DV;
  logic [31:0] i_bus_data;
  logic        i_bus_DV;
  logic        o_timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  bus_arbiter #(.WATCHDOG_W(4)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_if_req        (i_if_req),
    .i_if_address    (i_if_address),
    .o_if_data       (o_if_data),
    .o_if_done       (o_if_done),
    .i_ls_req        (i_ls_req),
    .i_ls_address    (i_ls_address),
    .i_ls_data       (i_ls_data),
    .i_ls_bhw        (i_ls_bhw),
    .i_ls_write      (i_ls_write),
    .o_ls_data       (o_ls_data),
    .o_ls_done       (o_ls_done),
    .o_ls_err        (o_ls_err),
    .o_bus_address   (o_bus_address),
    .o_bus_data      (o_bus_data),
    .o_bhw           (o_bhw),
    .o_write_notread (o_write_notread),
    .o_bus_DV        (o_bus_DV),
    .i_bus_data      (i_bus_data),
    .i_bus_DV        (i_bus_DV),
    .o_timeout       (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_if_req = 1'b0; i_if_address = 32'h0;
    i_ls_req = 1'b0; i_ls_address = 32'h0; i_ls_data = 32'h0;
    i_ls_bhw = 3'b100; i_ls_write = 1'b0;
    i_bus_DV = 1'b0; i_bus_data = 32'h0;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  // Memory side: wait lat cycles, then a one-cycle completion; returns in the done cycle
  task automatic respond(input int lat, input logic [31:0] rdata);
    repeat (lat) tick();
    i_bus_DV = 1'b1;
    i_bus_data = rdata;
    tick();
    i_bus_DV = 1'b0;
    i_bus_data = $urandom;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #3;
    tests_run++;
    if ({o_if_data, o_if_done, o_ls_data, o_ls_done, o_ls_err, o_bus_address, o_bus_data,
         o_bhw, o_write_notread, o_bus_DV, o_timeout} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got bus_DV=%b addr=%h done=%b/%b timeout=%b required all zero",
               o_bus_DV, o_bus_address, o_if_done, o_ls_done, o_timeout);
    end
    do_reset();
    tests_run++;
    if ({o_bus_DV, o_if_done, o_ls_done, o_ls_err} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got %b required 0000",
               {o_bus_DV, o_if_done, o_ls_done, o_ls_err});
    end
  endtask

  task automatic test_if_read();
    i_if_req = 1'b1;
    i_if_address = 32'h0000_0010;
    tick();
    tests_run++;
    if ({o_bus_DV, o_bhw, o_write_notread, o_bus_address} !== {1'b1, 3'b100, 1'b0, 32'h0000_0010}) begin
      tests_failed++;
      $display("[TB] FAIL if_issue: got DV=%b bhw=%b wr=%b addr=%h required 1 100 0 00000010",
               o_bus_DV, o_bhw, o_write_notread, o_bus_address);
    end
    respond(3, 32'hDEAD_BEEF);
    tests_run++;
    if ({o_if_done, o_if_data, o_ls_done} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL if_done: got done=%b data=%h ls_done=%b required 1 deadbeef 0",
               o_if_done, o_if_data, o_ls_done);
    end
    i_if_req = 1'b0;
    tick();
    tests_run++;
    if ({o_if_done, o_ls_done, o_bus_DV} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL if_done_single: got %b required 000", {o_if_done, o_ls_done, o_bus_DV});
    end
  endtask

  task automatic test_round_robin();
    logic        exp_ls;
    logic [31:0] exp_addr;
    do_reset();
    i_if_req = 1'b1; i_if_address = 32'h0000_0100;
    i_ls_req = 1'b1; i_ls_address = 32'h0000_0200; i_ls_bhw = 3'b100; i_ls_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_ls   = (k % 2) == 1;
      exp_addr = exp_ls ? 32'h0000_0200 : 32'h0000_0100;
      tick();
      tests_run++;
      if ({o_bus_DV, o_bus_address} !== {1'b1, exp_addr}) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant%0d: got DV=%b addr=%h required 1 %h", k, o_bus_DV, o_bus_address, exp_addr);
      end
      respond(1, 32'h1000_0000 + k);
      tests_run++;
      if ({o_if_done, o_ls_done} !== {~exp_ls, exp_ls}) begin
        tests_failed++;
        $display("[TB] FAIL rr_done%0d: got if=%b ls=%b required if=%b ls=%b", k, o_if_done, o_ls_done, ~exp_ls, exp_ls);
      end
      if (k == 3) begin
        i_if_req = 1'b0;
        i_ls_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_masking();
    logic [31:0] addr_t [2]  = '{32'h0000_1003, 32'h0000_1002};
    logic [2:0]  bhw_t  [2]  = '{3'b001, 3'b010};
    logic [31:0] mem_t  [2]  = '{32'hFFFF_FFA5, 32'h1234_BEEF};
    logic [31:0] exp_t  [2]  = '{32'h0000_00A5, 32'h0000_BEEF};
    for (int k = 0; k < 2; k++) begin
      i_ls_req = 1'b1; i_ls_address = addr_t[k]; i_ls_bhw = bhw_t[k];
      i_ls_write = 1'b0; i_ls_data = 32'h0;
      tick();
      tests_run++;
      if ({o_bus_DV, o_bhw, o_write_notread, o_bus_address} !== {1'b1, bhw_t[k], 1'b0, addr_t[k]}) begin
        tests_failed++;
        $display("[TB] FAIL mask_issue%0d: got DV=%b bhw=%b addr=%h required bhw=%b addr=%h",
                 k, o_bus_DV, o_bhw, o_bus_address, bhw_t[k], addr_t[k]);
      end
      respond(2, mem_t[k]);
      tests_run++;
      if ({o_ls_done, o_ls_err, o_ls_data, o_if_done} !== {1'b1, 1'b0, exp_t[k], 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL mask_data%0d: got done=%b err=%b data=%h required 1 0 %h",
                 k, o_ls_done, o_ls_err, o_ls_data, exp_t[k]);
      end
      i_ls_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_write();
    i_ls_req = 1'b1; i_ls_address = 32'h0000_2000; i_ls_bhw = 3'b010;
    i_ls_write = 1'b1; i_ls_data = 32'h0000_CAFE;
    tick();
    tests_run++;
    if ({o_bus_DV, o_bhw, o_write_notread, o_bus_data, o_bus_address} !==
        {1'b1, 3'b010, 1'b1, 32'h0000_CAFE, 32'h0000_2000}) begin
      tests_failed++;
      $display("[TB] FAIL write_issue: got DV=%b bhw=%b wr=%b data=%h addr=%h required 1 010 1 0000cafe 00002000",
               o_bus_DV, o_bhw, o_write_notread, o_bus_data, o_bus_address);
    end
    // master-side changes while busy must not disturb the bus
    i_ls_data = 32'h5555_5555;
    i_ls_address = 32'h0000_9999;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if ({o_bus_DV, o_bhw, o_write_notread, o_bus_data, o_bus_address, o_ls_done} !==
          {1'b0, 3'b010, 1'b1, 32'h0000_CAFE, 32'h0000_2000, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL write_hold%0d: got DV=%b bhw=%b wr=%b data=%h addr=%h done=%b",
                 k, o_bus_DV, o_bhw, o_write_notread, o_bus_data, o_bus_address, o_ls_done);
      end
    end
    respond(0, 32'h0);
    tests_run++;
    if ({o_ls_done, o_ls_err, o_if_done} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL write_done: got %b required 100", {o_ls_done, o_ls_err, o_if_done});
    end
    i_ls_req = 1'b0; i_ls_write = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    i_ls_req = 1'b1; i_ls_address = 32'h0000_3000; i_ls_bhw = 3'b000; i_ls_write = 1'b0;
    tick();
    tests_run++;
    if ({o_bus_DV, o_ls_done, o_ls_err, o_ls_data, o_if_done} !== {3'b011, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL illegal_err: got DV=%b done=%b err=%b data=%h required 0 1 1 0",
               o_bus_DV, o_ls_done, o_ls_err, o_ls_data);
    end
    i_ls_req = 1'b0; i_ls_bhw = 3'b100;
    tick();
    tests_run++;
    if ({o_bus_DV, o_ls_done, o_ls_err} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL illegal_single: got %b required 000", {o_bus_DV, o_ls_done, o_ls_err});
    end
  endtask

  task automatic test_stray_after_reset();
    i_if_req = 1'b1; i_if_address = 32'h0000_4000;
    tick();
    tick();
    tick();
    i_rst = 1'b1;
    i_if_req = 1'b0;
    #2;
    i_rst = 1'b0;
    tick();
    i_bus_DV = 1'b1; i_bus_data = 32'hBAD0_BAD0;
    tick();
    i_bus_DV = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if ({o_if_done, o_ls_done, o_bus_DV} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL stray_ignored%0d: got %b required 000", k, {o_if_done, o_ls_done, o_bus_DV});
      end
      tick();
    end
    i_if_req = 1'b1; i_if_address = 32'h0000_4004;
    tick();
    tests_run++;
    if ({o_bus_DV, o_bus_address} !== {1'b1, 32'h0000_4004}) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_issue: got DV=%b addr=%h required 1 00004004", o_bus_DV, o_bus_address);
    end
    respond(2, 32'h0BAD_F00D);
    tests_run++;
    if ({o_if_done, o_if_data} !== {1'b1, 32'h0BAD_F00D}) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_done: got done=%b data=%h required 1 0badf00d", o_if_done, o_if_data);
    end
    i_if_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic        pend_if, pend_ls, last_was_if, win_ls, legal;
    logic [31:0] if_addr, ls_addr, ls_wdata, rdata, expected;
    logic [2:0]  ls_bhw;
    logic        ls_wr;
    logic [2:0]  bhw_pool [8] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b000, 3'b111};
    int          lat;
    do_reset();
    pend_if = 1'b0; pend_ls = 1'b0;
    last_was_if = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!pend_if && $urandom_range(1, 0) == 1) begin
        pend_if = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!pend_ls && $urandom_range(1, 0) == 1) begin
        pend_ls = 1'b1;
        ls_addr = $urandom;
        ls_wdata = $urandom;
        ls_bhw = bhw_pool[$urandom_range(7, 0)];
        ls_wr = $urandom_range(1, 0) == 1;
      end
      if (!pend_if && !pend_ls) begin
        pend_if = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      i_if_req = pend_if; i_if_address = if_addr;
      i_ls_req = pend_ls; i_ls_address = ls_addr; i_ls_data = ls_wdata;
      i_ls_bhw = ls_bhw; i_ls_write = ls_wr;
      // a lone requester wins; a tie goes to whoever was not served last
      if (pend_if && pend_ls) win_ls = last_was_if;
      else                    win_ls = pend_ls;
      legal = !win_ls || ls_bhw == 3'b100 || ls_bhw == 3'b010 || ls_bhw == 3'b001;
      tick();
      if (!legal) begin
        tests_run++;
        if ({o_bus_DV, o_ls_done, o_ls_err, o_ls_data, o_if_done} !== {3'b011, 32'h0, 1'b0}) begin
          tests_failed++;
          $display("[TB] FAIL rand%0d_err: got DV=%b done=%b err=%b data=%h required 0 1 1 0",
                   n, o_bus_DV, o_ls_done, o_ls_err, o_ls_data);
        end
      end else begin
        tests_run++;
        if (win_ls ? ({o_bus_DV, o_bhw, o_write_notread, o_bus_address, o_bus_data} !==
                      {1'b1, ls_bhw, ls_wr, ls_addr, ls_wdata})
                   : ({o_bus_DV, o_bhw, o_write_notread, o_bus_address} !==
                      {1'b1, 3'b100, 1'b0, if_addr})) begin
          tests_failed++;
          $display("[TB] FAIL rand%0d_issue: got DV=%b bhw=%b wr=%b addr=%h data=%h for port %s",
                   n, o_bus_DV, o_bhw, o_write_notread, o_bus_address, o_bus_data, win_ls ? "D" : "I");
        end
        lat = $urandom_range(4, 1);
        rdata = $urandom;
        if (win_ls && ls_bhw == 3'b001)      expected = rdata % 256;
        else if (win_ls && ls_bhw == 3'b010) expected = rdata % 65536;
        else                                 expected = rdata;
        respond(lat, rdata);
        tests_run++;
        if (win_ls ? ({o_ls_done, o_ls_err, o_ls_data, o_if_done} !== {2'b10, expected, 1'b0})
                   : ({o_if_done, o_if_data, o_ls_done} !== {1'b1, expected, 1'b0})) begin
          tests_failed++;
          $display("[TB] FAIL rand%0d_done: got if=%b/%h ls=%b/%h err=%b required port %s data %h",
                   n, o_if_done, o_if_data, o_ls_done, o_ls_data, o_ls_err, win_ls ? "D" : "I", expected);
        end
      end
      last_was_if = !win_ls;
      if (win_ls) begin
        pend_ls = 1'b0;
        i_ls_req = 1'b0;
      end else begin
        pend_if = 1'b0;
        i_if_req = 1'b0;
      end
      tick();
    end
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
    do_reset();
  endtask

  task automatic test_timeout();
    i_if_req = 1'b1; i_if_address = 32'h0000_5000;
    tick();
    tests_run++;
    if (o_bus_DV !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_issue: got DV=%b required 1", o_bus_DV);
    end
    repeat (15) tick();
    tests_run++;
    if (o_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_early: got %b required 0 after 14 wait cycles", o_timeout);
    end
    tick();
    tests_run++;
    if (o_timeout !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_set: got %b required 1 after 15 wait cycles", o_timeout);
    end
    repeat (3) tick();
    respond(0, 32'h7777_0001);
    tests_run++;
    if ({o_if_done, o_if_data, o_timeout} !== {1'b1, 32'h7777_0001, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_sticky: got done=%b data=%h timeout=%b required 1 77770001 1",
               o_if_done, o_if_data, o_timeout);
    end
    i_if_req = 1'b0;
    tick();
    do_reset();
    tests_run++;
    if (o_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_clear: got %b required 0 after reset", o_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_round_robin();
    test_masking();
    test_write();
    test_illegal();
    test_stray_after_reset();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
